// File: rtl/jt900h_prefetch.sv
// rtl/jt900h_prefetch.sv - byte prefetch queue with 16-bit bus refill for the 900H core
// Optional underrun counter output enabled by defining JT900H_PF_UNDERRUN_EN.
module jt900h_prefetch #(
    parameter int QW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        flush,
    input  logic [23:0] pc_in,
    input  logic [2:0]  adv,
    output logic [31:0] buf_dout,
    output logic [3:0]  buf_cnt,
    output logic [23:0] bus_addr,
    output logic        bus_rd,
    input  logic        bus_ok,
    input  logic [15:0] bus_din
`ifdef JT900H_PF_UNDERRUN_EN
    ,
    output logic [15:0] underrun
`endif
);
    localparam int AW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t          state_q, state_d;
    logic            bus_rd_q, bus_rd_d;
    logic [23:0]     bus_addr_q, bus_addr_d;
    logic [23:0]     fa_q, fa_d;
    logic            skip_q, skip_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [7:0]      queue_q [QW];
    logic [3:0]      adv_ext, eff_adv;
    logic            wr_en, wr_two;

    always_comb begin
        state_d    = state_q;
        bus_rd_d   = bus_rd_q;
        bus_addr_d = bus_addr_q;
        fa_d       = fa_q;
        skip_d     = skip_q;
        wr_en      = 1'b0;
        wr_two     = 1'b0;
        adv_ext    = {1'b0, adv};
        eff_adv    = (adv_ext > cnt_q) ? cnt_q : adv_ext;

        case (state_q)
            IDLE: begin
                if (!flush && cnt_q <= 4'(QW - 2)) begin
                    state_d    = FETCH;
                    bus_rd_d   = 1'b1;
                    bus_addr_d = fa_q;
                end
            end
            FETCH: begin
                if (bus_ok) begin
                    state_d  = IDLE;
                    bus_rd_d = 1'b0;
                    if (!flush) begin
                        wr_en  = 1'b1;
                        wr_two = !skip_q;
                        skip_d = 1'b0;
                        fa_d   = fa_q + 24'd2;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus_ok) begin
                    state_d  = IDLE;
                    bus_rd_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_d  = rd_q + eff_adv[AW-1:0];
        cnt_d = cnt_q - eff_adv + (wr_en ? (wr_two ? 4'd2 : 4'd1) : 4'd0);
        wr_d  = wr_q + (wr_en ? (wr_two ? AW'(2) : AW'(1)) : AW'(0));

        // A flush discards everything queued and any data arriving this cycle
        if (flush) begin
            cnt_d  = 4'd0;
            rd_d   = '0;
            wr_d   = '0;
            fa_d   = {pc_in[23:1], 1'b0};
            skip_d = pc_in[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bus_rd_q   <= 1'b0;
            bus_addr_q <= 24'd0;
            fa_q       <= 24'd0;
            skip_q     <= 1'b0;
            cnt_q      <= 4'd0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else if (cen) begin
            state_q    <= state_d;
            bus_rd_q   <= bus_rd_d;
            bus_addr_q <= bus_addr_d;
            fa_q       <= fa_d;
            skip_q     <= skip_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cen && wr_en) begin
            if (wr_two) begin
                queue_q[wr_q]          <= bus_din[7:0];
                queue_q[wr_q + AW'(1)] <= bus_din[15:8];
            end else begin
                queue_q[wr_q] <= bus_din[15:8];
            end
        end
    end

    // Bytes beyond the valid count read as zero so stale queue contents never leak
    always_comb begin
        buf_dout = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (4'(k) < cnt_q) begin
                buf_dout[8*k +: 8] = queue_q[rd_q + AW'(k)];
            end
        end
    end

    assign buf_cnt  = cnt_q;
    assign bus_rd   = bus_rd_q;
    assign bus_addr = bus_addr_q;

`ifdef JT900H_PF_UNDERRUN_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 16'd0;
        end else if (cen && !flush && adv_ext > cnt_q && underrun_q != 16'hFFFF) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun = underrun_q;
`endif
endmodule

// File: tb/tb_jt900h_prefetch.sv
// tb/tb_jt900h_prefetch.sv - directed and randomized bench for jt900h_prefetch
module tb_jt900h_prefetch;
    localparam int QW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        flush = 1'b0;
    logic [23:0] pc_in = 24'd0;
    logic [2:0]  adv = 3'd0;
    logic        bus_ok = 1'b0;
    logic [15:0] bus_din = 16'd0;
    logic [31:0] buf_dout;
    logic [3:0]  buf_cnt;
    logic [23:0] bus_addr;
    logic        bus_rd;
`ifdef JT900H_PF_UNDERRUN_EN
    logic [15:0] underrun;
`endif

    int checks = 0;
    int errors = 0;

    // Reference: byte stream queue plus a pending-read / discard flag pair
    logic [7:0]  mq[$];
    logic [23:0] m_fa, m_addr;
    bit          m_skip, m_pend, m_disc;
    int          m_und;

    jt900h_prefetch #(.QW(QW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .flush    (flush),
        .pc_in    (pc_in),
        .adv      (adv),
        .buf_dout (buf_dout),
        .buf_cnt  (buf_cnt),
        .bus_addr (bus_addr),
        .bus_rd   (bus_rd),
        .bus_ok   (bus_ok),
        .bus_din  (bus_din)
`ifdef JT900H_PF_UNDERRUN_EN
        ,
        .underrun (underrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        mq.delete();
        m_fa = 0; m_addr = 0; m_skip = 0; m_pend = 0; m_disc = 0; m_und = 0;
    endtask

    task automatic m_edge();
        int cnt;
        int eff;
        cnt = mq.size();
        eff = (int'(adv) > cnt) ? cnt : int'(adv);
        if (cen) begin
            if (!flush && int'(adv) > cnt && m_und < 65535) m_und++;
            if (flush) begin
                mq.delete();
                m_fa = {pc_in[23:1], 1'b0};
                m_skip = pc_in[0];
                if (m_pend) begin
                    if (bus_ok) begin m_pend = 0; m_disc = 0; end
                    else m_disc = 1;
                end
            end else begin
                repeat (eff) void'(mq.pop_front());
                if (m_pend) begin
                    if (bus_ok) begin
                        if (!m_disc) begin
                            if (!m_skip) mq.push_back(bus_din[7:0]);
                            mq.push_back(bus_din[15:8]);
                            m_fa = m_fa + 24'd2;
                            m_skip = 0;
                        end
                        m_pend = 0;
                        m_disc = 0;
                    end
                end else if (cnt <= QW - 2) begin
                    m_pend = 1;
                    m_addr = m_fa;
                end
            end
        end
    endtask

    function automatic logic [31:0] m_dout();
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 4; k++) if (k < mq.size()) r[8*k +: 8] = mq[k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic restart(input logic [23:0] pc);
        cen = 1'b0; flush = 1'b0; adv = 3'd0; bus_ok = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_reset();
        cen = 1'b1; flush = 1'b1; pc_in = pc;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_rd !== 1'b0 || bus_addr !== 24'd0 || buf_cnt !== 4'd0 || buf_dout !== 32'd0) begin
            errors++;
            $display("FAIL reset: rd=%b addr=%h cnt=%0d dout=%h, want 0/0/0/0", bus_rd, bus_addr, buf_cnt, buf_dout);
        end
    endtask

    task automatic test_aligned();
        restart(24'h001000);
        tick();
        checks++;
        if (bus_rd !== 1'b1 || bus_addr !== 24'h001000) begin
            errors++; $display("FAIL aligned_req1: rd=%b addr=%h, want 1/001000", bus_rd, bus_addr);
        end
        bus_ok = 1'b1; bus_din = 16'h2211; tick();
        bus_ok = 1'b0; tick();
        checks++;
        if (bus_rd !== 1'b1 || bus_addr !== 24'h001002) begin
            errors++; $display("FAIL aligned_req2: rd=%b addr=%h, want 1/001002", bus_rd, bus_addr);
        end
        bus_ok = 1'b1; bus_din = 16'h4433; tick();
        bus_ok = 1'b0;
        checks++;
        if (buf_dout !== 32'h44332211 || buf_cnt !== 4'd4) begin
            errors++; $display("FAIL aligned_data: dout=%h cnt=%0d, want 44332211/4", buf_dout, buf_cnt);
        end
    endtask

    task automatic test_odd();
        restart(24'h001001);
        tick();
        checks++;
        if (bus_addr !== 24'h001000) begin
            errors++; $display("FAIL odd_addr: addr=%h, want 001000", bus_addr);
        end
        bus_ok = 1'b1; bus_din = 16'h2211; tick();
        bus_ok = 1'b0;
        checks++;
        if (buf_cnt !== 4'd1 || buf_dout !== 32'h00000022) begin
            errors++; $display("FAIL odd_data: cnt=%0d dout=%h, want 1/00000022", buf_cnt, buf_dout);
        end
    endtask

    task automatic test_full();
        restart(24'h002000);
        for (int i = 0; i < 20 && mq.size() < QW; i++) begin
            bus_ok = m_pend; bus_din = 16'($urandom); tick();
        end
        bus_ok = 1'b0;
        checks++;
        if (buf_cnt !== 4'(QW) || buf_dout !== m_dout()) begin
            errors++; $display("FAIL full_cnt: cnt=%0d dout=%h, want %0d/%h", buf_cnt, buf_dout, QW, m_dout());
        end
        repeat (3) begin
            tick();
            checks++;
            if (bus_rd !== 1'b0) begin
                errors++; $display("FAIL full_hold: rd=%b, want 0", bus_rd);
            end
        end
        adv = 3'd2; tick();
        adv = 3'd0;
        checks++;
        if (buf_cnt !== 4'(QW - 2) || bus_rd !== 1'b0) begin
            errors++; $display("FAIL full_adv: cnt=%0d rd=%b, want %0d/0", buf_cnt, bus_rd, QW - 2);
        end
        tick();
        checks++;
        if (bus_rd !== 1'b1 || bus_addr !== 24'h002008) begin
            errors++; $display("FAIL full_refill: rd=%b addr=%h, want 1/002008", bus_rd, bus_addr);
        end
    endtask

    task automatic test_drop();
        restart(24'h003000);
        tick();
        flush = 1'b1; pc_in = 24'h004005; tick();
        flush = 1'b0;
        checks++;
        if (bus_rd !== 1'b1 || bus_addr !== 24'h003000 || buf_cnt !== 4'd0) begin
            errors++; $display("FAIL drop_hold: rd=%b addr=%h cnt=%0d, want 1/003000/0", bus_rd, bus_addr, buf_cnt);
        end
        bus_ok = 1'b1; bus_din = 16'hBEEF; tick();
        bus_ok = 1'b0;
        checks++;
        if (bus_rd !== 1'b0 || buf_cnt !== 4'd0 || buf_dout !== 32'd0) begin
            errors++; $display("FAIL drop_discard: rd=%b cnt=%0d dout=%h, want 0/0/0", bus_rd, buf_cnt, buf_dout);
        end
        tick();
        checks++;
        if (bus_rd !== 1'b1 || bus_addr !== 24'h004004 || buf_cnt !== 4'd0) begin
            errors++; $display("FAIL drop_newreq: rd=%b addr=%h cnt=%0d, want 1/004004/0", bus_rd, bus_addr, buf_cnt);
        end
        bus_ok = 1'b1; bus_din = 16'h1234; tick();
        bus_ok = 1'b0;
        checks++;
        if (buf_cnt !== 4'd1 || buf_dout !== 32'h00000012) begin
            errors++; $display("FAIL drop_return: cnt=%0d dout=%h, want 1/00000012", buf_cnt, buf_dout);
        end
    endtask

    task automatic test_adv_clamp();
        restart(24'h005001);
        tick();
        bus_ok = 1'b1; bus_din = 16'hAABB; tick();
        bus_ok = 1'b0; tick();
        bus_ok = 1'b1; bus_din = 16'hCCDD; tick();
        bus_ok = 1'b0; tick();
        checks++;
        if (buf_cnt !== 4'd3 || bus_rd !== 1'b1) begin
            errors++; $display("FAIL clamp_setup: cnt=%0d rd=%b, want 3/1", buf_cnt, bus_rd);
        end
        bus_ok = 1'b1; bus_din = 16'h1122; adv = 3'd1; tick();
        bus_ok = 1'b0;
        checks++;
        if (buf_cnt !== 4'd4 || buf_dout !== 32'h1122CCDD) begin
            errors++; $display("FAIL clamp_ackadv: cnt=%0d dout=%h, want 4/1122ccdd", buf_cnt, buf_dout);
        end
        adv = 3'd2; tick();
        adv = 3'd4; tick();
        adv = 3'd0;
        checks++;
        if (buf_cnt !== 4'd0 || buf_dout !== 32'd0) begin
            errors++; $display("FAIL clamp_under: cnt=%0d dout=%h, want 0/0", buf_cnt, buf_dout);
        end
`ifdef JT900H_PF_UNDERRUN_EN
        checks++;
        if (underrun !== 16'd1) begin
            errors++; $display("FAIL clamp_count: underrun=%0d, want 1", underrun);
        end
`endif
    endtask

    task automatic test_async_reset();
        restart(24'h006000);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_rd !== 1'b0 || bus_addr !== 24'd0 || buf_cnt !== 4'd0 || buf_dout !== 32'd0) begin
            errors++; $display("FAIL async_reset: rd=%b addr=%h cnt=%0d dout=%h, want all 0", bus_rd, bus_addr, buf_cnt, buf_dout);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus_rd !== 1'b1 || bus_addr !== 24'd0) begin
            errors++; $display("FAIL reset_restart: rd=%b addr=%h, want 1/000000", bus_rd, bus_addr);
        end
    endtask

    task automatic test_random();
        int bad;
        restart(24'($urandom));
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            cen     = ($urandom_range(0, 7) != 0);
            flush   = ($urandom_range(0, 24) == 0);
            pc_in   = 24'($urandom);
            adv     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            bus_ok  = m_pend && ($urandom_range(0, 2) == 0);
            bus_din = 16'($urandom);
            tick();
            checks++;
            if (buf_cnt !== 4'(mq.size()) || buf_dout !== m_dout() || bus_rd !== m_pend || bus_addr !== m_addr) begin
                errors++;
                if (bad < 5) $display("FAIL random cyc %0d: cnt=%0d dout=%h rd=%b addr=%h, want %0d/%h/%b/%h",
                    i, buf_cnt, buf_dout, bus_rd, bus_addr, mq.size(), m_dout(), m_pend, m_addr);
                bad++;
            end
`ifdef JT900H_PF_UNDERRUN_EN
            checks++;
            if (underrun !== 16'(m_und)) begin
                errors++; $display("FAIL random_underrun cyc %0d: %0d, want %0d", i, underrun, m_und);
            end
`endif
        end
        cen = 1'b1; flush = 1'b0; adv = 3'd0; bus_ok = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_odd();
        test_full();
        test_drop();
        test_adv_clamp();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
